pixel_fifo: RTL
===============

PIXEL_FIFO -- requirements
Module: pixel_fifo

Interface
REQ-001 Parameter DEPTH, default 16, storage depth in pixels; SHALL be a power of two and at least 16.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  synchronous clear: end of mode 3, window start, or line restart.
REQ-005 push_en  input  1  fetcher pushes one 8-pixel tile row this cycle.
REQ-006 push_px  input  8 x ppu_pixel_t  tile row; push_px[0] is the leftmost pixel, displayed first.
REQ-007 push_ready  output  1  high when count <= DEPTH-8, i.e. a full row fits.
REQ-008 discard_load  input  1  line start; loads the fine-scroll discard counter.
REQ-009 discard_n  input  3  pixels to drop at line start (SCX[2:0]).
REQ-010 pop_en  input  1  consumer pops the head pixel at this edge.
REQ-011 top_px  output  ppu_pixel_t  head pixel, combinational from storage.
REQ-012 empty  output  1  no displayable pixel at head.
REQ-013 count  output  $clog2(DEPTH)+1  pixels currently stored, discard-pending pixels included.

Function
REQ-014 Storage SHALL be a circular buffer with head pointer, tail pointer and count; both pointers wrap modulo DEPTH.
REQ-015 A push with push_en=1 and push_ready=1 SHALL write push_px[i] at tail+i (mod DEPTH) for i=0..7, then advance tail by 8 and count by 8.
REQ-016 A push with push_en=1 and push_ready=0 SHALL be ignored: no storage, pointer or count change.
REQ-017 push_ready SHALL be computed from the registered count only, never from same-cycle pop_en.
REQ-018 empty SHALL be 1 when count==0 or discard_cnt!=0, otherwise 0.
REQ-019 A pop with pop_en=1 and empty=0 SHALL advance head by 1 and decrement count by 1.
REQ-020 A pop with pop_en=1 and empty=1 SHALL be ignored.
REQ-021 top_px SHALL equal storage[head] with zero latency; its value while empty=1 is don't-care but SHALL be stable.
REQ-022 Simultaneous accepted push and pop SHALL update count by +7 in one cycle; head and tail SHALL each advance normally.
REQ-023 Discard state machine:
  - states: IDLE (discard_cnt==0) and DROP (discard_cnt!=0).
  - discard_load=1 SHALL set discard_cnt=discard_n, overriding any current value.
  - In DROP, with count!=0, the FIFO SHALL drop one head pixel per cycle (head+1, count-1, discard_cnt-1).
  - In DROP with count==0, the FIFO SHALL stall and hold discard_cnt.
  - The state SHALL return to IDLE when discard_cnt reaches 0.
REQ-024 In DROP, external pop_en SHALL be ignored; empty=1 already forbids it.
REQ-025 discard_load asserted in the same cycle as an internal drop SHALL win: discard_cnt=discard_n and no drop that cycle.
REQ-026 An internal drop and an accepted push in the same cycle SHALL give count +7.
REQ-027 flush=1 SHALL set head=0, tail=0, count=0 and discard_cnt=0 at the next edge.
REQ-028 flush SHALL take priority over push, pop, drop and discard_load in the same cycle.
REQ-029 Storage contents are not cleared by flush or reset.
REQ-030 count SHALL never exceed DEPTH and never underflow; any such event is a design error and SHALL fire an assertion.

Reset
REQ-031 reset=1 SHALL asynchronously force head=0, tail=0, count=0 and discard_cnt=0.
REQ-032 During reset: empty=1, push_ready=1, count=0.
REQ-033 Deassertion of reset mid-line SHALL leave the FIFO empty in IDLE; no stale pixels are visible.

Verification
REQ-034 Push row colors 0,1,2,3,0,1,2,3, then pop 8 cycles -> top_px.color sequence is 0,1,2,3,0,1,2,3; empty=1 after the 8th pop; count=0.
REQ-035 Push two rows (count=16), then push_en=1 -> ignored, push_ready=0, count stays 16; pop once -> count=15, push_ready=0; pop to count=8 -> push_ready=1.
REQ-036 Hold count=8, assert push and pop in the same cycle -> count=15, and order is preserved across the pointer wrap (head goes 15->0).
REQ-037 Load discard with discard_n=3, then push row 0..7 -> empty=1 for 3 cycles, then top_px is pixel 3 and count=5.
REQ-038 Load discard with discard_n=5 on an empty FIFO, wait 4 cycles -> discard_cnt holds 5; push a row -> drops 5, top_px is pixel 5.
REQ-039 With count=12 and discard pending, assert flush together with push_en -> count=0, empty=1, discard_cnt=0; apply async reset mid-drop -> outputs reach reset values before the next edge.

Source files
------------

// File: rtl/pixel_fifo.sv
// ---------------------------------------------------------------------------
// pixel_fifo
//
// Background/window pixel FIFO that sits between the tile fetcher and the
// LCD pixel output stage. The fetcher deposits whole 8-pixel tile rows, and
// the output stage removes one pixel per pop. At the start of a line the FIFO
// can silently throw away up to 7 leading pixels. This implements fine
// horizontal scrolling (SCX[2:0]).
//
// Parameters
//   DEPTH        storage depth in pixels. It must be a power of two and at
//                least 16, so that two full rows fit and the pointers wrap
//                for free.
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   reset        asynchronous, active-high reset of pointers, count and
//                discard state
//   flush        synchronous clear (end of mode 3, window start, line
//                restart)
//   push_en      fetcher offers one 8-pixel row this cycle
//   push_px      the row; push_px[0] is the leftmost pixel, shown first
//   push_ready   a full row fits (count <= DEPTH-8)
//   discard_load loads the fine-scroll discard counter with discard_n
//   discard_n    number of leading pixels to drop
//   pop_en       consumer takes the head pixel at this edge
//   top_px       head pixel, read combinationally from storage
//   empty        no displayable pixel at the head
//   count        pixels stored, including pixels still waiting to be
//                discarded
// ---------------------------------------------------------------------------
package ppu_pkg;
    typedef struct packed {
        logic [1:0] color;
        logic [2:0] palette;
        logic       bg_priority;
    } ppu_pixel_t;
endpackage

module pixel_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push_en,
    input  ppu_pixel_t [7:0]           push_px,
    output logic                       push_ready,
    input  logic                       discard_load,
    input  logic [2:0]                 discard_n,
    input  logic                       pop_en,
    output ppu_pixel_t                 top_px,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // IDLE means no leading pixels are pending removal.
    // DROP means discard_cnt is non-zero.
    typedef enum logic {
        IDLE,
        DROP
    } discard_state_t;

    ppu_pixel_t      mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [2:0]      discard_cnt;
    discard_state_t  state;

    logic            push_acc;
    logic            pop_acc;
    logic            drop_acc;
    logic [CW-1:0]   count_next;
    logic [2:0]      discard_next;

    // Readiness and emptiness come only from registered state. The fetcher
    // and the output stage therefore never form a combinational loop through
    // this FIFO.
    assign push_ready = (count <= CW'(DEPTH - 8));
    assign empty      = (count == '0) || (state == DROP);
    assign top_px     = mem[head];

    // Decide which operations are accepted this cycle. Flush cancels all of
    // them. A pending discard_load wins over the drop it would otherwise
    // race with. Pops cannot collide with drops, because DROP already forces
    // empty.
    always_comb begin
        push_acc = push_en && push_ready && !flush;
        pop_acc  = pop_en && !empty && !flush;
        drop_acc = (state == DROP) && (count != '0) && !discard_load && !flush;
    end

    // Next count and next discard value. A push adds a whole row. Either a
    // pop or a drop removes one pixel. Both can happen together, giving +7.
    always_comb begin
        count_next = count;
        if (push_acc) begin
            count_next = count_next + CW'(8);
        end
        if (pop_acc || drop_acc) begin
            count_next = count_next - CW'(1);
        end

        discard_next = discard_cnt;
        if (discard_load) begin
            discard_next = discard_n;
        end else if (drop_acc) begin
            discard_next = discard_cnt - 3'd1;
        end
    end

    // Pointer, count and discard FSM state. Flush is a synchronous clear
    // that overrides every other operation. Head and tail rely on natural
    // power-of-two wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            discard_cnt <= '0;
            state       <= IDLE;
        end else if (flush) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            discard_cnt <= '0;
            state       <= IDLE;
        end else begin
            if (push_acc) begin
                tail <= tail + AW'(8);
            end
            if (pop_acc || drop_acc) begin
                head <= head + AW'(1);
            end
            count       <= count_next;
            discard_cnt <= discard_next;
            state       <= (discard_next != 3'd0) ? DROP : IDLE;
        end
    end

    // Pixel storage is deliberately left out of reset and flush. Only the
    // pointers define what is valid, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            for (int i = 0; i < 8; i++) begin
                mem[tail + AW'(i)] <= push_px[i];
            end
        end
    end

    // Occupancy can never leave 0..DEPTH. Removing from an empty store or
    // overfilling the buffer means the control logic above is broken.
    assert property (@(posedge clk) disable iff (reset) count <= CW'(DEPTH));
    assert property (@(posedge clk) disable iff (reset)
                     (pop_acc || drop_acc) |-> (count != '0));
    assert property (@(posedge clk) disable iff (reset)
                     count_next <= CW'(DEPTH));

endmodule
